// File: rtl/network_bf_in_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : network_bf_in_pipe_pkg
// Description : Shared constants and helpers for the NTT bank-to-butterfly
//               input crossbar.
// Revision    : 1.0 - initial release
// ============================================================================
package network_bf_in_pipe_pkg;

    localparam int c_DATA_W_DEFAULT = 12;

    // Butterfly operand lane indices for the radix-2 pair layout
    localparam int c_LANE_U0 = 0;
    localparam int c_LANE_V0 = 1;
    localparam int c_LANE_U1 = 2;
    localparam int c_LANE_V1 = 3;

    function automatic int f_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/network_sel_delay.sv
`default_nettype none
// ============================================================================
// Module      : network_sel_delay
// Description : DEPTH-stage {valid, data} shift line with flush; aligns lane
//               selects with coefficient RAM read data.
// Revision    : 1.0 - initial release
// ============================================================================
module network_sel_delay
    import network_bf_in_pipe_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,      // active-low, asynchronous
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_flush,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [W:0] r_q;
        logic [W:0] w_d;

        if (gi == 0) begin : g_head
            assign w_d = {i_valid, i_data};
        end else begin : g_body
            assign w_d = g_stage[gi-1].r_q;
        end

        // Payload is cleared along with valid so nothing undefined ever reaches the router
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_q <= '0;
            end else if (i_flush) begin
                r_q <= '0;
            end else begin
                r_q <= w_d;
            end
        end
    end

    assign {o_valid, o_data} = g_stage[DEPTH-1].r_q;

endmodule
`default_nettype wire

// File: rtl/network_bf_in_pipe.sv
`default_nettype none
// ============================================================================
// Module      : network_bf_in_pipe
// Description : Bank-to-butterfly input crossbar with delayed lane selects,
//               registered output, sticky conflict flag/counter and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module network_bf_in_pipe
    import network_bf_in_pipe_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEFAULT,
    parameter int NUM_BANK = 4,
    parameter int SEL_W    = f_clog2(NUM_BANK),
    parameter int MEM_LAT  = 1,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,        // active-low, asynchronous
    input  logic                       sel_valid,
    input  logic [NUM_BANK*SEL_W-1:0]  sel,
    input  logic [NUM_BANK*DATA_W-1:0] q,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic                       out_valid,
    output logic [NUM_BANK*DATA_W-1:0] bf_data,
    output logic [NUM_BANK-1:0]        lane_hit,
    output logic                       conflict,
    output logic [CNT_W-1:0]           conflict_cnt
);

    logic                       w_tail_valid;
    logic [NUM_BANK*SEL_W-1:0]  w_tail_sel;
    logic [NUM_BANK*DATA_W-1:0] w_lanes;
    logic [NUM_BANK-1:0]        w_hit;
    logic                       w_conflict;
    logic                       w_conf_evt;

    logic                       r_out_valid;
    logic [NUM_BANK*DATA_W-1:0] r_bf_data;
    logic [NUM_BANK-1:0]        r_lane_hit;
    logic                       r_conflict;
    logic [CNT_W-1:0]           r_conflict_cnt;

    network_sel_delay #(
        .W     (NUM_BANK*SEL_W),
        .DEPTH (MEM_LAT)
    ) u_sel_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (sel_valid),
        .i_data  (sel),
        .i_flush (flush),
        .o_valid (w_tail_valid),
        .o_data  (w_tail_sel)
    );

    // Banks are scanned in ascending order so the highest-index bank wins a shared lane
    always_comb begin
        w_lanes    = '0;
        w_hit      = '0;
        w_conflict = 1'b0;
        if (w_tail_valid) begin
            for (int l = 0; l < NUM_BANK; l++) begin
                for (int b = 0; b < NUM_BANK; b++) begin
                    if (w_tail_sel[b*SEL_W +: SEL_W] == SEL_W'(l)) begin
                        w_lanes[l*DATA_W +: DATA_W] = q[b*DATA_W +: DATA_W];
                        w_hit[l]                    = 1'b1;
                    end
                end
            end
            // NUM_BANK banks onto NUM_BANK lanes: any unhit lane means two banks collided
            w_conflict = ~&w_hit;
        end
    end

    // A beat dropped by flush never reaches the output, so it raises no conflict
    assign w_conf_evt = w_conflict & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid    <= 1'b0;
            r_bf_data      <= '0;
            r_lane_hit     <= '0;
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
                r_bf_data   <= '0;
                r_lane_hit  <= '0;
            end else begin
                r_out_valid <= w_tail_valid;
                r_bf_data   <= w_lanes;
                r_lane_hit  <= w_hit;
            end

            if (w_conf_evt) begin
                r_conflict <= 1'b1;
                if (clr_err) begin
                    r_conflict_cnt <= CNT_W'(1);
                end else if (r_conflict_cnt != {CNT_W{1'b1}}) begin
                    r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
                end
            end else if (clr_err) begin
                r_conflict     <= 1'b0;
                r_conflict_cnt <= '0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign bf_data      = r_bf_data;
    assign lane_hit     = r_lane_hit;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_network_bf_in_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_network_bf_in_pipe
// Description : Self-checking bench: default build (4 banks, latency 1) and a
//               wide build (8 banks, latency 3) against a scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_network_bf_in_pipe;
    import network_bf_in_pipe_pkg::*;

    localparam int c_LAT_A = 1;
    localparam int c_LAT_B = 3;

    typedef struct {
        logic [191:0] data;
        logic [15:0]  hit;
        int           cyc;
    } sb_t;

    typedef struct {
        logic [7:0]  sel;
        logic [47:0] q;
        logic [47:0] exp_data;
        logic [3:0]  exp_hit;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    // DUT A: defaults
    logic        sel_valid_a = 1'b0, flush_a = 1'b0, clr_a = 1'b0;
    logic [7:0]  sel_a = '0;
    logic [47:0] q_a = '0;
    logic        out_valid_a, conflict_a;
    logic [47:0] bf_data_a;
    logic [3:0]  lane_hit_a;
    logic [7:0]  cnt_a;
    // DUT B: 8 banks, latency 3
    logic        sel_valid_b = 1'b0, flush_b = 1'b0, clr_b = 1'b0;
    logic [23:0] sel_b = '0;
    logic [95:0] q_b = '0;
    logic        out_valid_b, conflict_b;
    logic [95:0] bf_data_b;
    logic [7:0]  lane_hit_b;
    logic [7:0]  cnt_b;

    // Next-cycle stimulus, consumed by step()
    logic        nv_a = 0, nf_a = 0, nc_a = 0, nt_a = 0;
    logic [7:0]  ns_a = '0;
    logic [47:0] nq_a = '0, ne_a = '0;
    logic [3:0]  nh_a = '0;
    logic        nv_b = 0, nf_b = 0, nc_b = 0;
    logic [23:0] ns_b = '0;
    logic [95:0] nq_b = '0;

    logic [47:0] qp_a [c_LAT_A];
    logic [95:0] qp_b [c_LAT_B];
    sb_t         sb_a [$];
    sb_t         sb_b [$];
    bit          conf_m [2];
    int          cnt_m [2];
    bit          clrp [2];
    vec_t        tab [6];

    network_bf_in_pipe #(.DATA_W(12), .NUM_BANK(4), .MEM_LAT(c_LAT_A), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .sel_valid(sel_valid_a), .sel(sel_a), .q(q_a),
        .flush(flush_a), .clr_err(clr_a), .out_valid(out_valid_a), .bf_data(bf_data_a),
        .lane_hit(lane_hit_a), .conflict(conflict_a), .conflict_cnt(cnt_a)
    );

    network_bf_in_pipe #(.DATA_W(12), .NUM_BANK(8), .SEL_W(3), .MEM_LAT(c_LAT_B), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .sel_valid(sel_valid_b), .sel(sel_b), .q(q_b),
        .flush(flush_b), .clr_err(clr_b), .out_valid(out_valid_b), .bf_data(bf_data_b),
        .lane_hit(lane_hit_b), .conflict(conflict_b), .conflict_cnt(cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] pack4(input logic [11:0] u0, v0, u1, v1);
        logic [47:0] r;
        r = '0;
        r[c_LANE_U0*12 +: 12] = u0;
        r[c_LANE_V0*12 +: 12] = v0;
        r[c_LANE_U1*12 +: 12] = u1;
        r[c_LANE_V1*12 +: 12] = v1;
        return r;
    endfunction

    function automatic sb_t route(input logic [63:0] s, input logic [191:0] qv, input int nb, input int sw);
        sb_t r;
        int  lane;
        r.data = '0;
        r.hit  = '0;
        r.cyc  = 0;
        for (int b = 0; b < nb; b++) begin
            lane = int'((s >> (b*sw)) & ((64'd1 << sw) - 64'd1));
            r.data[lane*12 +: 12] = qv[b*12 +: 12];
            r.hit[lane] = 1'b1;
        end
        return r;
    endfunction

    // Drive one cycle on both DUTs and update the scoreboards
    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        q_a = qp_a[c_LAT_A-1];
        for (int i = c_LAT_A-1; i > 0; i--) qp_a[i] = qp_a[i-1];
        qp_a[0] = nq_a;
        q_b = qp_b[c_LAT_B-1];
        for (int i = c_LAT_B-1; i > 0; i--) qp_b[i] = qp_b[i-1];
        qp_b[0] = nq_b;
        sel_valid_a = nv_a; sel_a = ns_a; flush_a = nf_a; clr_a = nc_a;
        sel_valid_b = nv_b; sel_b = ns_b; flush_b = nf_b; clr_b = nc_b;
        if (nf_a) begin
            while (sb_a.size() > 0 && sb_a[$].cyc >= cyc - c_LAT_A) void'(sb_a.pop_back());
        end else if (nv_a) begin
            if (nt_a) begin
                e.data = 192'(ne_a);
                e.hit  = 16'(nh_a);
            end else begin
                e = route(64'(ns_a), 192'(nq_a), 4, 2);
            end
            e.cyc = cyc;
            sb_a.push_back(e);
        end
        if (nf_b) begin
            while (sb_b.size() > 0 && sb_b[$].cyc >= cyc - c_LAT_B) void'(sb_b.pop_back());
        end else if (nv_b) begin
            e = route(64'(ns_b), 192'(nq_b), 8, 3);
            e.cyc = cyc;
            sb_b.push_back(e);
        end
        nv_a = 0; nf_a = 0; nc_a = 0; nt_a = 0;
        ns_a = 8'($urandom); nq_a = {16'($urandom), $urandom};
        nv_b = 0; nf_b = 0; nc_b = 0;
        ns_b = 24'($urandom); nq_b = {$urandom, $urandom, $urandom};
    endtask

    task automatic mon(input int id, input logic ov, input logic [191:0] d, input logic [15:0] h,
                       input logic cf, input logic [7:0] cnt, input logic clr_now);
        sb_t e;
        bit  empty;
        int  nb  = (id == 0) ? 4 : 8;
        int  lat = (id == 0) ? c_LAT_A : c_LAT_B;
        empty = 1'b0;
        if (clrp[id]) begin
            conf_m[id] = 1'b0;
            cnt_m[id]  = 0;
        end
        if (ov) begin
            if (id == 0) begin
                if (sb_a.size() == 0) empty = 1'b1; else e = sb_a.pop_front();
            end else begin
                if (sb_b.size() == 0) empty = 1'b1; else e = sb_b.pop_front();
            end
            if (empty) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dut%0d unexpected beat: got data %0h expected no beat", id, d);
            end else begin
                chk($sformatf("dut%0d bf_data", id), d, e.data);
                chk($sformatf("dut%0d lane_hit", id), 192'(h), 192'(e.hit));
                chk($sformatf("dut%0d out cycle", id), 192'(cyc), 192'(e.cyc + lat + 1));
                if ($countones(e.hit) != nb) begin
                    conf_m[id] = 1'b1;
                    if (cnt_m[id] != 255) cnt_m[id]++;
                end
            end
        end else begin
            chk($sformatf("dut%0d idle bf_data", id), d, '0);
            chk($sformatf("dut%0d idle lane_hit", id), 192'(h), '0);
        end
        chk($sformatf("dut%0d conflict", id), 192'(cf), 192'(conf_m[id]));
        chk($sformatf("dut%0d conflict_cnt", id), 192'(cnt), 192'(cnt_m[id]));
        clrp[id] = clr_now;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            conf_m = '{0, 0};
            cnt_m  = '{0, 0};
            clrp   = '{0, 0};
        end else if (mon_en) begin
            mon(0, out_valid_a, 192'(bf_data_a), 16'(lane_hit_a), conflict_a, cnt_a, clr_a);
            mon(1, out_valid_b, 192'(bf_data_b), 16'(lane_hit_b), conflict_b, cnt_b, clr_b);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid_a"}, 192'(out_valid_a), '0);
        chk({tag, " bf_data_a"}, 192'(bf_data_a), '0);
        chk({tag, " lane_hit_a"}, 192'(lane_hit_a), '0);
        chk({tag, " conflict_a"}, 192'(conflict_a), '0);
        chk({tag, " cnt_a"}, 192'(cnt_a), '0);
        chk({tag, " out_valid_b"}, 192'(out_valid_b), '0);
        chk({tag, " bf_data_b"}, 192'(bf_data_b), '0);
        chk({tag, " cnt_b"}, 192'(cnt_b), '0);
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    initial begin
        int lat;
        for (int i = 0; i < c_LAT_A; i++) qp_a[i] = '0;
        for (int i = 0; i < c_LAT_B; i++) qp_b[i] = '0;
        tab[0] = '{8'hE4, {12'hD03, 12'hC02, 12'hB01, 12'hA00}, pack4(12'hA00, 12'hB01, 12'hC02, 12'hD03), 4'hF};
        tab[1] = '{8'h1B, {12'h444, 12'h333, 12'h222, 12'h111}, pack4(12'h444, 12'h333, 12'h222, 12'h111), 4'hF};
        tab[2] = '{8'h21, {12'h0BB, 12'h456, 12'h0AA, 12'h123}, pack4(12'h0BB, 12'h123, 12'h456, 12'h000), 4'b0111};
        tab[3] = '{8'h39, {12'h004, 12'h003, 12'h002, 12'h001}, pack4(12'h004, 12'h001, 12'h002, 12'h003), 4'hF};
        tab[4] = '{8'hFF, {12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC}, pack4(12'h000, 12'h000, 12'h000, 12'hFFF), 4'b1000};
        tab[5] = '{8'hB1, {12'h7A4, 12'h7A3, 12'h7A2, 12'h7A1}, pack4(12'h7A2, 12'h7A1, 12'h7A4, 12'h7A3), 4'hF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        #2 rst = 1'b1;
        mon_en = 1'b1;
        drain(2);

        // Latency: identity vector on A, random beat on B
        nv_a = 1; nt_a = 1; ns_a = tab[0].sel; nq_a = tab[0].q; ne_a = tab[0].exp_data; nh_a = tab[0].exp_hit;
        step();
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            step();
            @(negedge clk);
            if (out_valid_a) lat = k;
        end
        chk("latency A", 192'(lat), 192'(2));
        nv_b = 1;
        step();
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            step();
            @(negedge clk);
            if (out_valid_b) lat = k;
        end
        chk("latency B", 192'(lat), 192'(4));
        drain(4);

        // Table vectors back-to-back on A
        for (int i = 0; i < 6; i++) begin
            nv_a = 1; nt_a = 1; ns_a = tab[i].sel; nq_a = tab[i].q;
            ne_a = tab[i].exp_data; nh_a = tab[i].exp_hit;
            step();
        end
        drain(4);
        @(negedge clk);
        chk("table conflict_a", 192'(conflict_a), 192'(1));
        chk("table cnt_a", 192'(cnt_a), 192'(2));
        nc_a = 1; nc_b = 1;
        step();
        drain(1);
        @(negedge clk);
        chk("clear cnt_a", 192'(cnt_a), '0);

        // Streaming with flush on the 4th issue cycle, both builds
        for (int i = 1; i <= 8; i++) begin
            nv_a = 1; nv_b = 1;
            nf_a = (i == 4); nf_b = (i == 4);
            step();
        end
        drain(6);
        chk("flush drain A", 192'(sb_a.size()), '0);
        chk("flush drain B", 192'(sb_b.size()), '0);

        // Saturation then clear interplay on A
        for (int i = 0; i < 300; i++) begin
            nv_a = 1; ns_a = 8'h00;
            step();
        end
        drain(3);
        @(negedge clk);
        chk("saturated cnt_a", 192'(cnt_a), 192'(255));
        chk("saturated conflict_a", 192'(conflict_a), 192'(1));
        nv_a = 1; ns_a = 8'h00;
        step();
        nc_a = 1;
        step();
        step();
        @(negedge clk);
        chk("clr+conflict cnt_a", 192'(cnt_a), 192'(1));
        chk("clr+conflict conflict_a", 192'(conflict_a), 192'(1));
        nc_a = 1;
        step();
        step();
        @(negedge clk);
        chk("clr alone cnt_a", 192'(cnt_a), '0);
        chk("clr alone conflict_a", 192'(conflict_a), '0);

        // Asynchronous reset with beats in flight
        for (int i = 0; i < 5; i++) begin
            nv_a = 1; nv_b = 1;
            step();
        end
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        sel_valid_a = 0; sel_valid_b = 0; flush_a = 0; flush_b = 0; clr_a = 0; clr_b = 0;
        sb_a.delete();
        sb_b.delete();
        @(posedge clk);
        @(posedge clk);
        #4 rst = 1'b1;
        drain(6);
        nv_b = 1;
        step();
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            step();
            @(negedge clk);
            if (out_valid_b) lat = k;
        end
        chk("latency B after reset", 192'(lat), 192'(4));
        drain(6);
        chk("final drain A", 192'(sb_a.size()), '0);
        chk("final drain B", 192'(sb_b.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
